// File: rtl/rgb2raw_mosaic.sv
// RGB to Bayer RAW re-mosaic: picks one colour per pixel from the Bayer phase
// of internal x/y counters, tags line/frame markers, and drives a 2-entry skid output.
module rgb2raw_mosaic #(
  parameter int DW      = 12,
  parameter int WIDTH   = 1920,
  parameter int HEIGHT  = 1080,
  parameter int PATTERN = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] i_r,
  input  logic [DW-1:0] i_g,
  input  logic [DW-1:0] i_b,
  input  logic          i_valid,
  input  logic          i_sof,
  output logic          o_ready,
  output logic [DW-1:0] o_data,
  output logic          o_valid,
  output logic          o_sof,
  output logic          o_eol,
  output logic          o_eof,
  output logic          o_x_odd,
  output logic          o_y_odd,
  input  logic          i_ready,
  output logic          o_err_sof
);

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  // Packed sample layout: {data, sof, eol, eof, x_odd, y_odd}
  localparam int PW = DW + 5;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  localparam logic [1:0]    PAT    = 2'(PATTERN);

  logic [XW-1:0] x_q, x_d, px;
  logic [YW-1:0] y_q, y_d, py;
  logic          main_valid_q, main_valid_d;
  logic          skid_valid_q, skid_valid_d;
  logic [PW-1:0] main_q, main_d, skid_q, skid_d, pix;
  logic          err_q, err_d;
  logic          accept, xfer, at_origin;
  logic [1:0]    ph;
  logic [DW-1:0] sel;

  always_comb begin
    accept    = i_valid & ~skid_valid_q;
    xfer      = main_valid_q & i_ready;
    at_origin = (x_q == '0) && (y_q == '0);

    // An accepted SOF forces this pixel to the frame origin
    px = i_sof ? '0 : x_q;
    py = i_sof ? '0 : y_q;

    ph = {py[0], px[0]} ^ PAT;
    case (ph)
      2'b00:   sel = i_r;
      2'b11:   sel = i_b;
      default: sel = i_g;
    endcase

    pix = {sel,
           (px == '0) && (py == '0),
           px == X_LAST,
           (px == X_LAST) && (py == Y_LAST),
           px[0],
           py[0]};

    x_d = x_q;
    y_d = y_q;
    if (accept) begin
      if (px == X_LAST) begin
        x_d = '0;
        y_d = (py == Y_LAST) ? '0 : py + 1'b1;
      end else begin
        x_d = px + 1'b1;
        y_d = py;
      end
    end

    err_d = accept & i_sof & ~at_origin;

    main_valid_d = main_valid_q;
    main_d       = main_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (!main_valid_q || xfer) begin
      // Skid always drains first so ordering is preserved
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) main_d = pix;
      end
    end else if (accept) begin
      skid_d       = pix;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      x_q          <= '0;
      y_q          <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
      err_q        <= err_d;
    end
  end

  assign o_ready   = ~skid_valid_q;
  assign o_valid   = main_valid_q;
  assign o_data    = main_q[PW-1 -: DW];
  assign o_sof     = main_q[4];
  assign o_eol     = main_q[3];
  assign o_eof     = main_q[2];
  assign o_x_odd   = main_q[1];
  assign o_y_odd   = main_q[0];
  assign o_err_sof = err_q;

endmodule
